// File: rtl/eth_frame_tx_if.sv
// eth_frame_tx_if: Avalon-ST beat bundle between the frame source and its sink
interface eth_frame_tx_if;
  logic [31:0] data_out;
  logic        sop;
  logic        eop;
  logic [1:0]  empty;
  logic        valid;
  logic        ready;
  logic        error;
  modport master(output data_out, sop, eop, empty, valid, error, input ready);
  modport slave(input data_out, sop, eop, empty, valid, error, output ready);
endinterface

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: replays show-ahead FIFO words as Avalon-ST frames, with length check and underflow abort
module eth_frame_tx #(
  parameter int MAX_LEN         = 1518,
  parameter int UNDERFLOW_LIMIT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [13:0] frame_len,
  input  logic [31:0] fifo_q,
  input  logic        rdempty,
  output logic        rdreq,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  eth_frame_tx_if.master st
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;
  localparam int UW = $clog2(UNDERFLOW_LIMIT + 1);
  logic [1:0]    state;
  logic [11:0]   words_left;
  logic [1:0]    last_empty;
  logic [UW-1:0] uf_cnt;
  logic          sent;
  logic          slot_free;
  logic          load;
  logic          bad_len;
  logic          starving;
  // slot is free when nothing is held or the held beat is taken this cycle
  always_comb begin
    slot_free = !st.valid || st.ready;
    load      = state == SEND && slot_free && !rdempty && words_left != 12'd0;
    bad_len   = frame_len == 14'd0 || frame_len > 14'(MAX_LEN);
    starving  = state == SEND && words_left != 12'd0 && rdempty;
  end
  assign rdreq = load;
  assign busy  = state != IDLE;
  // frame sequencing, output beat register and underflow watchdog
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state       <= IDLE;
      words_left  <= 12'd0;
      last_empty  <= 2'd0;
      uf_cnt      <= '0;
      sent        <= 1'b0;
      done        <= 1'b0;
      len_err     <= 1'b0;
      st.data_out <= 32'd0;
      st.sop      <= 1'b0;
      st.eop      <= 1'b0;
      st.empty    <= 2'd0;
      st.valid    <= 1'b0;
      st.error    <= 1'b0;
    end else begin
      done    <= 1'b0;
      len_err <= 1'b0;
      if (state == IDLE) begin
        if (start && bad_len)
          len_err <= 1'b1;
        else if (start) begin
          words_left <= 12'((frame_len + 14'd3) >> 2);
          last_empty <= 2'd0 - frame_len[1:0];
          uf_cnt     <= '0;
          sent       <= 1'b0;
          state      <= SEND;
        end
      end else if (state == SEND) begin
        if (load) begin
          st.data_out <= fifo_q;
          st.valid    <= 1'b1;
          st.sop      <= !sent;
          st.eop      <= words_left == 12'd1;
          st.empty    <= words_left == 12'd1 ? last_empty : 2'd0;
          words_left  <= words_left - 12'd1;
          sent        <= 1'b1;
          uf_cnt      <= '0;
        end else if (slot_free) begin
          st.valid <= 1'b0;
          st.sop   <= 1'b0;
          st.eop   <= 1'b0;
          st.empty <= 2'd0;
        end
        if (st.valid && st.ready && st.eop) begin
          state <= IDLE;
          done  <= 1'b1;
        end else if (starving) begin
          uf_cnt <= uf_cnt + UW'(1);
          if (uf_cnt == UW'(UNDERFLOW_LIMIT - 1))
            state <= ABORT;
        end
      end else begin
        if (st.valid && st.ready && st.error) begin
          state       <= IDLE;
          done        <= 1'b1;
          st.valid    <= 1'b0;
          st.sop      <= 1'b0;
          st.eop      <= 1'b0;
          st.error    <= 1'b0;
        end else if (slot_free) begin
          st.data_out <= 32'd0;
          st.sop      <= !sent;
          st.eop      <= 1'b1;
          st.empty    <= 2'd0;
          st.error    <= 1'b1;
          st.valid    <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: randomized frame replay against a queue-based frame model
module tb_eth_frame_tx;
  localparam int UL = 4;
  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
    logic        err;
  } beat_t;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] frame_len = 14'd0;
  logic [31:0] fifo_q;
  logic        rdempty;
  logic        rdreq, busy, done, len_err;
  eth_frame_tx_if st();
  eth_frame_tx #(.MAX_LEN(1518), .UNDERFLOW_LIMIT(UL)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .frame_len(frame_len),
    .fifo_q(fifo_q), .rdempty(rdempty), .rdreq(rdreq), .busy(busy),
    .done(done), .len_err(len_err), .st(st)
  );
  always #5 clk = ~clk;
  logic [31:0] fq[$];
  beat_t       eq[$];
  logic        rq[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, exp_words = 0, exp_pops = 0, fpops = 0, rdy_pct = 100;
  logic pend = 0, model_busy = 0, done_pend = 0, lerr_pend = 0, lat_chk = 0, stall = 0;
  logic [37:0] snap;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void upd_fifo();
    rdempty = fq.size() == 0;
    fifo_q  = rdempty ? 32'hdead_beef : fq[0];
  endfunction
  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    upd_fifo();
  endtask
  // expected beats for a legal command: the FIFO head words, then an abort beat if the FIFO runs short
  task automatic expect_frame(input int len);
    int w, n, pad;
    w = (len + 3) / 4;
    n = fq.size() < w ? fq.size() : w;
    pad = (4 - len % 4) % 4;
    for (int i = 0; i < n; i++)
      eq.push_back('{fq[i], i == 0, i == w - 1, (i == w - 1) ? 2'(pad) : 2'd0, 1'b0});
    if (n < w) eq.push_back('{32'd0, n == 0, 1'b1, 2'd0, 1'b1});
    exp_words = w;
    exp_pops  = n;
    lat_chk   = rdy_pct == 100 && rq.size() == 0 && n == w;
  endtask
  task automatic step(input logic s, input logic [13:0] l);
    beat_t b, e;
    logic  exp_done;
    @(negedge clk);
    cyc++;
    if (pend) begin
      e.d = fq.pop_front();
      fpops++;
      pend = 0;
    end
    upd_fifo();
    st.ready  = rq.size() != 0 ? rq.pop_front() : ($urandom_range(99) < rdy_pct);
    start     = s;
    frame_len = l;
    #1;
    b = '{st.data_out, st.sop, st.eop, st.empty, st.error};
    if (stall) chk("stall_hold", {st.valid, b}, snap);
    exp_done  = done_pend;
    done_pend = 0;
    if (exp_done) model_busy = 0;
    chk("done", done, exp_done);
    chk("busy", busy, model_busy);
    chk("len_err", len_err, lerr_pend);
    lerr_pend = 0;
    if (exp_done) chk("frame_pops", fpops, exp_pops);
    if (exp_done && lat_chk) begin
      chk("done_latency", cyc - start_cyc, exp_words + 2);
      lat_chk = 0;
    end
    if (lat_chk && cyc == start_cyc + 1) chk("first_rdreq", rdreq, 1);
    if (s && !model_busy) begin
      if (l == 14'd0 || l > 14'd1518) lerr_pend = 1;
      else begin
        expect_frame(int'(l));
        model_busy = 1;
        start_cyc  = cyc;
        fpops      = 0;
      end
    end
    if (st.valid && st.ready) begin
      if (eq.size() == 0) chk("extra_beat", st.valid, 0);
      else begin
        e = eq.pop_front();
        chk("beat", b, e);
        if (e.eop) done_pend = 1;
      end
    end
    stall = st.valid && !st.ready;
    snap  = {st.valid, b};
    if (stall) chk("stall_rdreq", rdreq, 0);
    chk("rdreq_empty", rdreq && rdempty, 0);
    pend = rdreq;
  endtask
  task automatic drain();
    int b = 0;
    while ((model_busy || eq.size() != 0 || done_pend || lerr_pend) && b < 3000) begin
      step(0, 14'd0);
      b++;
    end
    chk("drain_timeout", b < 3000, 1);
  endtask
  task automatic mid_reset();
    logic [31:0] t;
    @(negedge clk);
    cyc++;
    if (pend) t = fq.pop_front();
    upd_fifo();
    st.ready = 1'b1;
    #1;
    n_rst = 1'b0;
    pend  = 0;
    #1;
    chk("rst_async", {rdreq, busy, done, len_err, st.valid, st.sop, st.eop, st.error, st.empty, st.data_out}, 0);
    eq.delete();
    model_busy = 0;
    done_pend  = 0;
    lerr_pend  = 0;
    stall      = 0;
    lat_chk    = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask
  initial begin
    int len, w, nw;
    st.ready = 1'b0;
    upd_fifo();
    #1;
    chk("rst_state", {rdreq, busy, done, len_err, st.valid, st.sop, st.eop, st.error, st.empty, st.data_out}, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 14'd0);
      chk("idle_rdreq", rdreq, 0);
      chk("idle_valid", st.valid, 0);
    end
    rdy_pct = 100;
    push(32'h77777700); push(32'h2e707572); push(32'h64756500); push(32'h2e656475);
    step(1, 14'd14);
    drain();
    push(32'h77777700); push(32'h2e707572); push(32'h64756500); push(32'h2e656475);
    rq = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    step(1, 14'd14);
    drain();
    push(32'h0a0b0c0d);
    step(1, 14'd0);
    drain();
    step(1, 14'd1519);
    drain();
    chk("bad_len_no_pop", fq.size(), 1);
    step(1, 14'd4);
    drain();
    push(32'h11111111); push(32'h22222222);
    step(1, 14'd16);
    drain();
    push(32'h33333333);
    step(1, 14'd3);
    drain();
    for (int i = 0; i < 6; i++) push($urandom);
    step(1, 14'd16);
    repeat (3) step(0, 14'd0);
    mid_reset();
    step(1, 14'd8);
    drain();
    chk("fifo_left", fq.size(), 1);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(9))
        0: len = 0;
        1: len = 1519 + $urandom_range(200);
        default: len = $urandom_range(1, 64);
      endcase
      if (i == 7) len = 1518;
      w = (len + 3) / 4;
      nw = ($urandom_range(6) == 0 && w > 0) ? $urandom_range(0, w - 1) : w + $urandom_range(0, 2);
      if (len > 1518) nw = 0;
      for (int k = 0; k < nw; k++) push($urandom);
      rdy_pct = $urandom_range(1) == 0 ? 100 : $urandom_range(40, 99);
      step(1, 14'(len));
      if (len >= 1 && len <= 1518) begin
        step(1, 14'($urandom_range(1, 64)));
        step(1, 14'($urandom_range(1, 64)));
      end
      drain();
    end
    chk("sb_empty", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
